// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the sequential ALU.
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR,
        OP_LSL, OP_ASL, OP_LSR, OP_ASR, OP_MUL
    } alu_op_e;
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;
    typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result/flags response handshakes of alu_seq.
interface alu_seq_if #(parameter int N = 8);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic [3:0]   alucontrol;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [3:0]   output_flags;
    modport master(output in_valid, a_i, b_i, alucontrol, out_ready,
                   input in_ready, out_valid, result, output_flags);
    modport slave(input in_valid, a_i, b_i, alucontrol, out_ready,
                  output in_ready, out_valid, result, output_flags);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle; done_o flags the last
// iteration while p_o already carries the completed low N bits of a*b.
module alu_mul_iter #(parameter int N = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] p_o
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    logic [N-1:0]  acc_q, acc_d, a_q, b_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    assign acc_d  = acc_q + (b_q[0] ? a_q : '0);
    assign done_o = busy_q && (cnt_q == CW'(N - 1));
    assign busy_o = busy_q;
    assign p_o    = acc_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            acc_q  <= '0;
            a_q    <= a_i;
            b_q    <= b_i;
        end else if (busy_q) begin
            busy_q <= !done_o;
            cnt_q  <= cnt_q + 1'b1;
            acc_q  <= acc_d;
            a_q    <= a_q << 1;
            b_q    <= b_q >> 1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with {C,N,V,Z} flags; define ALU_SEQ_MUL_EN to build
// the iterative multiplier for opcode 10 (otherwise it behaves as a reserved opcode).
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N) + 1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    alu_state_e       state_q, state_d;
    logic [N-1:0]     result_q, result_d, alu_r, b_eff;
    logic [3:0]       flags_q, flags_d, alu_f;
    logic [N:0]       sum, lsl, lsr;
    logic signed [N:0] asr;
    logic             c, v, accept;
    logic [SHW-1:0]   s;
    alu_op_e          op;
    assign op     = alu_op_e'(bus.alucontrol);
    assign s      = bus.b_i[SHW-1:0];
    assign accept = bus.in_valid && (state_q == IDLE);
    // SUB reuses the adder as a + ~b + 1, so C=1 means no borrow
    always_comb begin
        b_eff = (op == OP_SUB) ? ~bus.b_i : bus.b_i;
        sum   = {1'b0, bus.a_i} + {1'b0, b_eff} + {{N{1'b0}}, op == OP_SUB};
        lsl   = {1'b0, bus.a_i} << s;
        lsr   = {bus.a_i, 1'b0} >> s;
        asr   = $signed({bus.a_i, 1'b0}) >>> s;
        alu_r = '0;
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_r = sum[N-1:0];
                c     = sum[N];
                v     = (bus.a_i[N-1] == b_eff[N-1]) && (sum[N-1] != bus.a_i[N-1]);
            end
            OP_AND:         alu_r = bus.a_i & bus.b_i;
            OP_OR:          alu_r = bus.a_i | bus.b_i;
            OP_NOT:         alu_r = ~bus.a_i;
            OP_XOR:         alu_r = bus.a_i ^ bus.b_i;
            OP_LSL, OP_ASL: {c, alu_r} = lsl;
            OP_LSR:         {alu_r, c} = lsr;
            OP_ASR:         {alu_r, c} = asr;
            default:        alu_r = '0;
        endcase
    end
    assign alu_f = {c, alu_r[N-1], v, ~|alu_r};
`ifdef ALU_SEQ_MUL_EN
    logic         mul_busy, mul_done;
    logic [N-1:0] mul_p;
    alu_mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && (op == OP_MUL)),
        .a_i     (bus.a_i),
        .b_i     (bus.b_i),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .p_o     (mul_p)
    );
`endif
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) state_d = MUL;
                    else begin
                        state_d  = DONE;
                        result_d = alu_r;
                        flags_d  = alu_f;
                    end
`else
                    state_d  = DONE;
                    result_d = alu_r;
                    flags_d  = alu_f;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d  = DONE;
                    result_d = mul_p;
                    flags_d  = {1'b0, mul_p[N-1], 1'b0, ~|mul_p};
                end else if (!mul_busy) state_d = IDLE;
            end
`endif
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end
    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.output_flags = flags_q;
endmodule
